rans_ctrl: RTL and testbench

RANS_CTRL -- requirements
Module: rans_ctrl

---
 rtl/rans_ctrl_if.sv | 45 ++++
 rtl/rans_ctrl.sv | 134 +++++++++++++
 tb/tb_rans_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rans_ctrl_if.sv
// rtl/rans_ctrl_if.sv - handshake and datapath bundle between the host side and rans_ctrl
interface rans_ctrl_if #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8
);
  // control
  logic                    start_i;
  logic                    abort_i;
  // frequency table stream
  logic                    tbl_valid_i;
  logic                    tbl_ready_o;
  logic [RESOLUTION-1:0]   tbl_freq_i;
  logic [RESOLUTION-1:0]   tbl_cum_i;
  // symbol stream
  logic                    sym_valid_i;
  logic                    sym_ready_o;
  logic [SYMBOL_WIDTH-1:0] sym_i;
  logic                    sym_last_i;
  // rANS datapath
  logic                    rans_ready_i;
  logic                    freq_wr_o;
  logic [RESOLUTION-1:0]   freq_o;
  logic [RESOLUTION-1:0]   cum_freq_o;
  logic [SYMBOL_WIDTH-1:0] symb_o;
  logic                    en_o;
  // status
  logic                    busy_o;
  logic                    done_o;
  logic                    err_o;
  logic [31:0]             sym_cnt_o;

  modport master (
    output start_i, abort_i, tbl_valid_i, tbl_freq_i, tbl_cum_i,
           sym_valid_i, sym_i, sym_last_i, rans_ready_i,
    input  tbl_ready_o, sym_ready_o, freq_wr_o, freq_o, cum_freq_o,
           symb_o, en_o, busy_o, done_o, err_o, sym_cnt_o
  );

  modport slave (
    input  start_i, abort_i, tbl_valid_i, tbl_freq_i, tbl_cum_i,
           sym_valid_i, sym_i, sym_last_i, rans_ready_i,
    output tbl_ready_o, sym_ready_o, freq_wr_o, freq_o, cum_freq_o,
           symb_o, en_o, busy_o, done_o, err_o, sym_cnt_o
  );
endinterface

// File: rtl/rans_ctrl.sv
// rtl/rans_ctrl.sv - rANS encoder controller: frequency table load, symbol streaming, flush
module rans_ctrl #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int NUM_RANS     = 4,
  parameter int FLUSH_CYCLES = 8
) (
  input logic         clk_i,
  input logic         rst_ni,
  rans_ctrl_if.slave  bus
);
  localparam int GW = $clog2(NUM_RANS + 2);
  localparam int FW = $clog2(FLUSH_CYCLES + 2);
  localparam logic [RESOLUTION:0] FULL_SUM = {1'b1, {RESOLUTION{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FLUSH} state_t;

  state_t                  state;
  logic [SYMBOL_WIDTH-1:0] idx;
  logic [RESOLUTION:0]     sum;
  logic [GW-1:0]           gap_cnt;
  logic [FW-1:0]           flush_cnt;
  logic                    freq_wr_q;
  logic [RESOLUTION-1:0]   freq_q;
  logic [RESOLUTION-1:0]   cum_q;
  logic [SYMBOL_WIDTH-1:0] symb_q;
  logic                    en_q;
  logic                    done_q;
  logic                    err_q;
  logic [31:0]             sym_cnt_q;

  logic                    tbl_ready;
  logic                    tbl_acc;
  logic                    sym_acc;
  logic                    last_entry;
  logic [RESOLUTION:0]     sum_next;

  // Table writes are spaced so every lane has absorbed the previous entry before the next one
  assign tbl_ready  = (state == LOAD) && bus.rans_ready_i && (gap_cnt == '0) && !freq_wr_q;
  assign tbl_acc    = bus.tbl_valid_i && tbl_ready;
  assign sym_acc    = bus.sym_valid_i && (state == STREAM);
  assign last_entry = &idx;
  assign sum_next   = sum + {1'b0, bus.tbl_freq_i};

  assign bus.tbl_ready_o = tbl_ready;
  assign bus.sym_ready_o = (state == STREAM);
  assign bus.freq_wr_o   = freq_wr_q;
  assign bus.freq_o      = freq_q;
  assign bus.cum_freq_o  = cum_q;
  assign bus.symb_o      = symb_q;
  assign bus.en_o        = en_q;
  assign bus.busy_o      = (state != IDLE);
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.sym_cnt_o   = sym_cnt_q;

  // Controller FSM with registered datapath strobes; abort overrides every other event
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      idx       <= '0;
      sum       <= '0;
      gap_cnt   <= '0;
      flush_cnt <= '0;
      freq_wr_q <= 1'b0;
      freq_q    <= '0;
      cum_q     <= '0;
      symb_q    <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sym_cnt_q <= '0;
    end else begin
      freq_wr_q <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

      if (bus.abort_i) begin
        state   <= IDLE;
        gap_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start_i) begin
              state     <= LOAD;
              idx       <= '0;
              sum       <= '0;
              gap_cnt   <= '0;
              sym_cnt_q <= '0;
              err_q     <= 1'b0;
            end
          end
          LOAD: begin
            if (tbl_acc) begin
              freq_wr_q <= 1'b1;
              symb_q    <= idx;
              freq_q    <= bus.tbl_freq_i;
              cum_q     <= bus.tbl_cum_i;
              gap_cnt   <= GW'(NUM_RANS);
              idx       <= idx + 1'b1;
              sum       <= sum_next;
              // cum must equal the sum of all earlier freqs; the full table must sum to 2^RESOLUTION
              if (({1'b0, bus.tbl_cum_i} != sum) || (last_entry && (sum_next != FULL_SUM)))
                err_q <= 1'b1;
              if (last_entry) state <= STREAM;
            end
          end
          STREAM: begin
            if (sym_acc) begin
              en_q   <= 1'b1;
              symb_q <= bus.sym_i;
              if (sym_cnt_q != '1) sym_cnt_q <= sym_cnt_q + 32'd1;
              if (bus.sym_last_i) begin
                state     <= FLUSH;
                flush_cnt <= '0;
              end
            end
          end
          FLUSH: begin
            // the first FLUSH cycle still carries en_o of the last symbol
            if (flush_cnt == FW'(FLUSH_CYCLES)) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rans_ctrl.sv
// tb/tb_rans_ctrl.sv - scoreboard testbench for rans_ctrl
module tb_rans_ctrl;
  localparam int RES  = 10;
  localparam int SW   = 8;
  localparam int NR   = 4;
  localparam int FC   = 8;
  localparam int NSYM = 1 << SW;

  typedef struct packed {
    logic [SW-1:0]  s;
    logic [RES-1:0] f;
    logic [RES-1:0] c;
  } tbl_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  tbl_t          tbl_q[$];
  logic [SW-1:0] sym_q[$];

  rans_ctrl_if #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW)) bus ();

  rans_ctrl #(
    .RESOLUTION(RES), .SYMBOL_WIDTH(SW), .NUM_RANS(NR), .FLUSH_CYCLES(FC)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [RES-1:0] cum_of(input int i, input int bad_idx);
    if (i == bad_idx) return RES'(27);
    return RES'(4 * i);
  endfunction

  task automatic test_reset();
    bus.start_i = 0; bus.abort_i = 0; bus.tbl_valid_i = 0; bus.tbl_freq_i = '0; bus.tbl_cum_i = '0;
    bus.sym_valid_i = 0; bus.sym_i = '0; bus.sym_last_i = 0; bus.rans_ready_i = 0;
    rst_n = 0;
    #3;
    tests++;
    if ({bus.tbl_ready_o, bus.sym_ready_o, bus.freq_wr_o, bus.freq_o, bus.cum_freq_o, bus.symb_o,
         bus.en_o, bus.busy_o, bus.done_o, bus.err_o, bus.sym_cnt_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b err=%b sym_cnt=%0d freq_wr=%b en=%b required all 0",
               bus.busy_o, bus.err_o, bus.sym_cnt_o, bus.freq_wr_o, bus.en_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    tests++;
    if (bus.busy_o !== 1'b0 || bus.tbl_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b tbl_ready=%b required 0 0", bus.busy_o, bus.tbl_ready_o);
    end
  endtask

  task automatic load_table(input int bad_idx, input int stall_idx, input int stop_after);
    int   idx, writes, cyc, last_wr, budget, stall_bad;
    bit   acc, skip_gap;
    tbl_t e;
    idx = 0; writes = 0; cyc = 0; last_wr = -1; budget = 0; acc = 0; skip_gap = 0;
    tbl_q.delete();
    bus.rans_ready_i = 1;
    bus.start_i = 1;
    @(negedge clk);
    bus.start_i = 0;
    tests++;
    if (bus.busy_o !== 1'b1 || bus.err_o !== 1'b0) begin
      fails++;
      $display("FAIL load_start: busy=%b err=%b required busy=1 err=0", bus.busy_o, bus.err_o);
    end
    bus.tbl_freq_i = RES'(4);
    bus.tbl_cum_i  = cum_of(idx, bad_idx);
    bus.tbl_valid_i = 1;
    while (writes < stop_after && budget < 4000) begin
      #1;
      acc = bus.tbl_ready_o && bus.tbl_valid_i;
      if (acc) tbl_q.push_back('{s: SW'(idx), f: bus.tbl_freq_i, c: bus.tbl_cum_i});
      @(negedge clk);
      cyc++; budget++;
      tests++;
      if (bus.freq_wr_o !== acc) begin
        fails++;
        $display("FAIL freq_wr_timing: freq_wr=%b required %b at entry %0d", bus.freq_wr_o, acc, idx);
      end
      if (bus.freq_wr_o === 1'b1 && tbl_q.size() > 0) begin
        e = tbl_q.pop_front();
        tests++;
        if ({bus.symb_o, bus.freq_o, bus.cum_freq_o} !== e) begin
          fails++;
          $display("FAIL table_write: symb=%0d freq=%0d cum=%0d required %0d %0d %0d",
                   bus.symb_o, bus.freq_o, bus.cum_freq_o, e.s, e.f, e.c);
        end
        tests++;
        if (bus.err_o !== (bad_idx >= 0 && int'(e.s) >= bad_idx)) begin
          fails++;
          $display("FAIL err_during_load: err=%b required %b at entry %0d",
                   bus.err_o, (bad_idx >= 0 && int'(e.s) >= bad_idx), e.s);
        end
        if (last_wr >= 0 && !skip_gap) begin
          tests++;
          if (cyc - last_wr != NR + 1) begin
            fails++;
            $display("FAIL write_spacing: %0d cycles required %0d", cyc - last_wr, NR + 1);
          end
        end
        last_wr = cyc; skip_gap = 0; writes++;
      end
      if (acc) begin
        idx++;
        if (idx < NSYM) bus.tbl_cum_i = cum_of(idx, bad_idx);
        if (idx == stall_idx) begin
          bus.rans_ready_i = 0;
          stall_bad = 0;
          repeat (20) begin
            @(negedge clk);
            cyc++;
            if (bus.tbl_ready_o !== 1'b0 || bus.freq_wr_o !== 1'b0) stall_bad++;
          end
          tests++;
          if (stall_bad != 0) begin
            fails++;
            $display("FAIL stall_quiet: %0d active cycles required 0", stall_bad);
          end
          bus.rans_ready_i = 1;
          #1;
          tests++;
          if (bus.tbl_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL stall_resume: tbl_ready=%b required 1", bus.tbl_ready_o);
          end
          skip_gap = 1;
        end
      end
    end
    bus.tbl_valid_i = 0;
    tests++;
    if (budget >= 4000) begin
      fails++;
      $display("FAIL load_timeout: %0d writes required %0d", writes, stop_after);
    end
  endtask

  task automatic stream_syms(input int n, input int abort_after, input bit exp_err);
    int  sent, k, budget, cnt, en_bad, done_seen;
    bit  acc;
    logic [SW-1:0] s;
    sent = 0; k = 0; budget = 0; acc = 0;
    sym_q.delete();
    while (sent < n && budget < 200) begin
      if (abort_after >= 0 && sent == abort_after) break;
      bus.sym_valid_i = (k % 2 == 0);
      bus.sym_i       = SW'(8'h11 + sent);
      bus.sym_last_i  = (sent == n - 1);
      #1;
      acc = bus.sym_valid_i && bus.sym_ready_o;
      if (acc) begin sym_q.push_back(bus.sym_i); sent++; end
      @(negedge clk);
      k++; budget++;
      tests++;
      if (bus.en_o !== acc) begin
        fails++;
        $display("FAIL en_pattern: en=%b required %b at cycle %0d", bus.en_o, acc, k);
      end
      if (bus.en_o === 1'b1 && sym_q.size() > 0) begin
        s = sym_q.pop_front();
        tests++;
        if (bus.symb_o !== s) begin
          fails++;
          $display("FAIL stream_symbol: symb=%h required %h", bus.symb_o, s);
        end
      end
    end
    bus.sym_valid_i = 0;
    bus.sym_last_i  = 0;
    if (abort_after >= 0) begin
      bus.abort_i = 1;
      @(negedge clk);
      bus.abort_i = 0;
      tests++;
      if (bus.busy_o !== 1'b0 || bus.en_o !== 1'b0 || bus.sym_cnt_o !== 32'(abort_after)) begin
        fails++;
        $display("FAIL abort_state: busy=%b en=%b sym_cnt=%0d required 0 0 %0d",
                 bus.busy_o, bus.en_o, bus.sym_cnt_o, abort_after);
      end
      done_seen = 0;
      repeat (FC + 6) begin
        @(negedge clk);
        if (bus.done_o !== 1'b0) done_seen++;
      end
      tests++;
      if (done_seen != 0) begin
        fails++;
        $display("FAIL abort_no_done: %0d done pulses required 0", done_seen);
      end
      return;
    end
    cnt = 0; en_bad = 0;
    while (bus.done_o !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (bus.en_o !== 1'b0) en_bad++;
    end
    tests++;
    if (cnt != FC + 1) begin
      fails++;
      $display("FAIL done_latency: %0d cycles required %0d", cnt, FC + 1);
    end
    tests++;
    if (en_bad != 0 || bus.sym_cnt_o !== 32'(n) || bus.err_o !== exp_err) begin
      fails++;
      $display("FAIL flush_state: en_cycles=%0d sym_cnt=%0d err=%b required 0 %0d %b",
               en_bad, bus.sym_cnt_o, bus.err_o, n, exp_err);
    end
    @(negedge clk);
    tests++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.err_o !== exp_err) begin
      fails++;
      $display("FAIL after_done: done=%b busy=%b err=%b required 0 0 %b",
               bus.done_o, bus.busy_o, bus.err_o, exp_err);
    end
  endtask

  task automatic test_table_load();
    load_table(-1, -1, NSYM);
    tests++;
    if (bus.sym_ready_o !== 1'b1 || bus.err_o !== 1'b0 || bus.tbl_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL enter_stream: sym_ready=%b err=%b tbl_ready=%b required 1 0 0",
               bus.sym_ready_o, bus.err_o, bus.tbl_ready_o);
    end
  endtask

  task automatic test_stream();
    stream_syms(10, -1, 1'b0);
  endtask

  task automatic test_table_error();
    load_table(7, -1, NSYM);
    tests++;
    if (bus.err_o !== 1'b1 || bus.sym_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL err_stream_entry: err=%b sym_ready=%b required 1 1", bus.err_o, bus.sym_ready_o);
    end
    stream_syms(2, -1, 1'b1);
  endtask

  task automatic test_stall_and_abort();
    load_table(-1, 50, NSYM);
    stream_syms(10, 3, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    load_table(-1, -1, 100);
    #2;
    rst_n = 0;
    #1;
    tests++;
    if ({bus.tbl_ready_o, bus.sym_ready_o, bus.freq_wr_o, bus.freq_o, bus.cum_freq_o, bus.symb_o,
         bus.en_o, bus.busy_o, bus.done_o, bus.err_o, bus.sym_cnt_o} !== '0) begin
      fails++;
      $display("FAIL async_reset: busy=%b symb=%0d freq=%0d cum=%0d required all 0",
               bus.busy_o, bus.symb_o, bus.freq_o, bus.cum_freq_o);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    load_table(-1, -1, NSYM);
    stream_syms(4, -1, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_table_load();
    test_stream();
    test_table_error();
    test_stall_and_abort();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
